// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared constants and the approximate low-row term for approx_mult_pipe
package approx_mult_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_L     = 4;
  localparam int PW        = 2 * DEF_WIDTH;

  // Widest operand the helper below can take; WIDTH of any instance must not exceed it.
  localparam int MAXW = 32;

  // OR-compressed contribution of the low L partial-product rows.
  // Only columns width .. width+l-2 are kept; everything below column width is dropped.
  function automatic logic [2*MAXW-1:0] approx_low_term(
    input logic [MAXW-1:0] x,
    input logic [MAXW-1:0] y,
    input int              width,
    input int              l
  );
    logic [2*MAXW-1:0] a;
    logic [2*MAXW-1:0] bit_v;
    logic [MAXW-1:0]   xs;
    logic [MAXW-1:0]   ys;
    a = '0;
    for (int i = 0; i < MAXW; i++) begin
      for (int j = 0; j < MAXW; j++) begin
        if (i < l && j < width && (i + j) >= width && (i + j) <= width + l - 2) begin
          xs    = x >> i;
          ys    = y >> j;
          bit_v = {{(2*MAXW-1){1'b0}}, xs[0] & ys[0]};
          a     = a | (bit_v << (i + j));
        end
      end
    end
    return a;
  endfunction

endpackage

// File: rtl/approx_mult_core.sv
// rtl/approx_mult_core.sv - combinational exact/approximate unsigned multiplier
module approx_mult_core
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int L     = DEF_L
) (
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               exact_mode,
  output logic [2*WIDTH-1:0] z
);

  localparam int ZW = 2 * WIDTH;

  logic [2*MAXW-1:0] low_full;
  logic [ZW-1:0]     low_approx;
  logic [ZW-1:0]     low_exact;
  logic [ZW-1:0]     high_rows;

  // Rows L and above are always exact and shared by both modes.
  assign high_rows  = (ZW'(y) * ZW'(x[WIDTH-1:L])) << L;

  // The low rows are either multiplied properly or replaced by the OR-compressed term.
  assign low_exact  = ZW'(y) * ZW'(x[L-1:0]);
  assign low_full   = approx_low_term(MAXW'(x), MAXW'(y), WIDTH, L);
  assign low_approx = low_full[ZW-1:0];

  assign z = high_rows + (exact_mode ? low_exact : low_approx);

endmodule

// File: rtl/approx_mult_pipe.sv
// rtl/approx_mult_pipe.sv - 2-stage valid/ready approximate multiplier; APPROX_ERR_MON_EN adds err/err_cnt
module approx_mult_pipe
  import approx_mult_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int L     = DEF_L
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic               exact_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               z_exact
`ifdef APPROX_ERR_MON_EN
  ,
  output logic [2*WIDTH-1:0] err,
  output logic [31:0]        err_cnt
`endif
);

  localparam int ZW = 2 * WIDTH;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic             s1_mode_q, s1_mode_d;

  logic             out_valid_q, out_valid_d;
  logic [ZW-1:0]    z_q, z_d;
  logic             z_exact_q, z_exact_d;

  logic [ZW-1:0]    core_z;
  logic             stall;
  logic             s2_load;

  approx_mult_core #(
    .WIDTH (WIDTH),
    .L     (L)
  ) u_core (
    .x          (s1_x_q),
    .y          (s1_y_q),
    .exact_mode (s1_mode_q),
    .z          (core_z)
  );

  // S1 may refill while S2 is stalled as long as S1 itself is empty.
  assign stall    = out_valid_q & ~out_ready;
  assign in_ready = ~stall | ~s1_valid_q;
  assign s2_load  = ~stall & s1_valid_q;

  // Next state for both stages: S2 advances unless stalled, S1 loads whenever it is ready.
  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_x_d      = s1_x_q;
    s1_y_d      = s1_y_q;
    s1_mode_d   = s1_mode_q;
    out_valid_d = out_valid_q;
    z_d         = z_q;
    z_exact_d   = z_exact_q;
    if (!stall) begin
      out_valid_d = s1_valid_q;
    end
    if (s2_load) begin
      z_d       = core_z;
      z_exact_d = s1_mode_q;
    end
    if (in_ready) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_x_d    = x;
        s1_y_d    = y;
        s1_mode_d = exact_mode;
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_mode_q   <= 1'b0;
      out_valid_q <= 1'b0;
      z_q         <= '0;
      z_exact_q   <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_mode_q   <= s1_mode_d;
      out_valid_q <= out_valid_d;
      z_q         <= z_d;
      z_exact_q   <= z_exact_d;
    end
  end

  assign out_valid = out_valid_q;
  assign z         = z_q;
  assign z_exact   = z_exact_q;

`ifdef APPROX_ERR_MON_EN
  logic [ZW-1:0] exact_full;
  logic [ZW-1:0] err_q, err_d;
  logic [31:0]   err_cnt_q, err_cnt_d;

  assign exact_full = ZW'(s1_x_q) * ZW'(s1_y_q);

  // Error travels with its result; the counter saturates instead of wrapping.
  always_comb begin
    err_d     = err_q;
    err_cnt_d = err_cnt_q;
    if (s2_load) begin
      err_d = exact_full - core_z;
    end
    if (out_valid_q && out_ready && (err_q != '0) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 32'd1;
    end
  end

  // Error monitor registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= '0;
      err_cnt_q <= '0;
    end else begin
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_approx_mult_pipe.sv
// tb/tb_approx_mult_pipe.sv - randomized scoreboard bench for approx_mult_pipe
module tb_approx_mult_pipe;

  localparam int W  = 8;
  localparam int LL = 4;
  localparam int ZW = 2 * W;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x;
  logic [W-1:0]  y;
  logic          exact_mode;
  logic          out_valid;
  logic          out_ready;
  logic [ZW-1:0] z;
  logic          z_exact;
`ifdef APPROX_ERR_MON_EN
  logic [ZW-1:0] err;
  logic [31:0]   err_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  approx_mult_pipe #(
    .WIDTH (W),
    .L     (LL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .y          (y),
    .exact_mode (exact_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .z          (z),
    .z_exact    (z_exact)
`ifdef APPROX_ERR_MON_EN
    ,
    .err        (err),
    .err_cnt    (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Approximate product = exact product minus the true low rows plus the OR-compressed columns.
  function automatic logic [ZW-1:0] ref_z(input int xv, input int yv, input bit mode);
    int exact_p;
    int low_rows;
    int a;
    bit any;
    int j;
    exact_p = xv * yv;
    if (mode) return ZW'(exact_p);
    low_rows = (xv % (1 << LL)) * yv;
    a = 0;
    for (int c = W; c <= W + LL - 2; c++) begin
      any = 1'b0;
      for (int i = 0; i < LL; i++) begin
        j = c - i;
        if (j >= 0 && j < W && ((xv >> i) & 1) == 1 && ((yv >> j) & 1) == 1) any = 1'b1;
      end
      if (any) a += (1 << c);
    end
    return ZW'(exact_p - low_rows + a);
  endfunction

  typedef struct {
    logic [ZW-1:0] z;
    bit            mode;
    logic [ZW-1:0] err;
  } exp_t;

  exp_t sb[$];
  int   n_acc = 0;
  int   n_out = 0;
  int   cyc   = 0;
  int   out_cyc[$];
  bit   held  = 1'b0;
  logic [ZW-1:0] held_z;
  int   exp_cnt = 0;

  always @(posedge clk) cyc++;

  // Scoreboard: outputs are checked before new accepts are queued.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      sb.delete();
      held    = 1'b0;
      exp_cnt = 0;
    end else begin
`ifdef APPROX_ERR_MON_EN
      check_eq("err_cnt", err_cnt, exp_cnt);
`endif
      if (held) begin
        check_eq("stall_valid", out_valid, 1);
        check_eq("stall_z", z, held_z);
      end
      held   = out_valid && !out_ready;
      held_z = z;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", out_valid, 0);
        end else begin
          e = sb.pop_front();
          check_eq("sb_z", z, e.z);
          check_eq("sb_z_exact", z_exact, e.mode);
`ifdef APPROX_ERR_MON_EN
          check_eq("sb_err", err, e.err);
          if (e.err != 0) exp_cnt++;
`endif
        end
        n_out++;
        out_cyc.push_back(cyc);
      end
      if (in_valid && in_ready) begin
        e.z    = ref_z(int'(x), int'(y), exact_mode);
        e.mode = exact_mode;
        e.err  = ZW'(int'(x) * int'(y)) - e.z;
        sb.push_back(e);
        n_acc++;
      end
    end
  end

  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input bit m);
    x          = xv;
    y          = yv;
    exact_mode = m;
    in_valid   = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check_eq("send_accept", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic run_one(input logic [W-1:0] xv, input logic [W-1:0] yv, input bit m,
                         input logic [ZW-1:0] exp_z);
    int lat;
    send(xv, yv, m);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
      lat++;
    end
    check_eq("latency", lat, 2);
    check_eq("direct_z", z, exp_z);
    check_eq("direct_z_exact", z_exact, m);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a0;
    int o0;
    bool_wait: begin end
    rst        = 1'b1;
    in_valid   = 1'b0;
    x          = '0;
    y          = '0;
    exact_mode = 1'b0;
    out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_z", z, 0);
    check_eq("rst_z_exact", z_exact, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    run_one(8'd255, 8'd255, 1'b1, 16'd65025);
    run_one(8'd255, 8'd255, 1'b0, 16'd62992);
`ifdef APPROX_ERR_MON_EN
    check_eq("err_255", err, 2033);
    check_eq("err_cnt_255", err_cnt, 1);
`endif
    run_one(8'd255, 8'd255, 1'b1, 16'd65025);
`ifdef APPROX_ERR_MON_EN
    check_eq("err_exact", err, 0);
    check_eq("err_cnt_exact", err_cnt, 1);
`endif
    run_one(8'd15, 8'd255, 1'b0, 16'd1792);
    run_one(8'd16, 8'd16, 1'b0, 16'd256);

    // Back-to-back approximate stream.
    o0 = n_out;
    out_cyc.delete();
    for (int k = 0; k < 10; k++) send(W'($urandom), W'($urandom), 1'b0);
    for (int k = 0; k < 10 && n_out < o0 + 10; k++) @(posedge clk);
    #1;
    check_eq("stream_count", n_out - o0, 10);
    if (out_cyc.size() >= 10) check_eq("stream_spacing", out_cyc[9] - out_cyc[0], 9);

    // Stall: two accepted, third blocked, then drained in order.
    out_ready = 1'b0;
    a0 = n_acc;
    o0 = n_out;
    send(W'($urandom), W'($urandom), 1'b0);
    send(W'($urandom), W'($urandom), 1'b1);
    x          = W'($urandom);
    y          = W'($urandom);
    exact_mode = 1'b0;
    in_valid   = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("stall_in_ready", in_ready, 0);
    check_eq("stall_accepted", n_acc - a0, 2);
    check_eq("stall_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 0; k < 10 && n_out < o0 + 3; k++) @(posedge clk);
    #1;
    check_eq("stall_drain_count", n_out - o0, 3);
    check_eq("stall_sb_empty", sb.size(), 0);

    // Reset with two transactions in flight.
    send(W'($urandom), W'($urandom), 1'b0);
    send(W'($urandom), W'($urandom), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_z", z, 0);
    @(posedge clk);
    #1;
    run_one(8'd200, 8'd100, 1'b0, ref_z(200, 100, 1'b0));

    // Random modes with random downstream backpressure.
    fork
      begin
        for (int k = 0; k < 30; k++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 10 && sb.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check_eq("soak_sb_empty", sb.size(), 0);
    check_eq("soak_out_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
